lii_gearbox_wrapper: RTL and testbench
======================================

LII_GEARBOX_WRAPPER -- requirements
Module: lii_gearbox_wrapper

Interface
REQ-001 SHALL have parameter PW, default 64, LII phy packing width in bits.
REQ-002 SHALL have parameter IW, default 16, kernel input word width; PW SHALL be an integer multiple of IW (RIN = PW/IW).
REQ-003 SHALL have parameter OW, default 16, kernel output word width; PW SHALL be an integer multiple of OW (ROUT = PW/OW).
REQ-004 SHALL have parameter LOCAL_ID, default 8'h00, this node's LII address.
REQ-005 SHALL have parameter DEST_ID, default 8'h01, LII destination for all output beats.
REQ-006 SHALL have parameter PKT_WORDS, default 0, output words per packet; 0 disables packet flush.
REQ-007 SHALL have one clock and an asynchronous, active-low reset, with ports aclk and arstn.
REQ-008 aclk  input  1  clock, all state on rising edge.
REQ-009 arstn  input  1  asynchronous active-low reset.
REQ-010 lii_in_p0_tdata/tvalid/src/dst  input  PW/1/8/8  phy input beat; lii_in_p0_tready output 1.
REQ-011 lii_out_p0_tdata/tvalid/src/dst  output  PW/1/8/8  phy output beat; lii_out_p0_tready input 1.
REQ-012 in_stream_tdata/tvalid  output  IW/1  kernel input; in_stream_tready input 1.
REQ-013 out_stream_tdata/tvalid  input  OW/1  kernel output; out_stream_tready output 1.
REQ-014 ce  output  1  kernel clock enable.
REQ-015 drop_cnt  output  16  saturating count of input beats discarded by address filter.

Function
REQ-016 Input unpacker SHALL hold one PW beat plus slice index 0..RIN-1; it presents slice [idx*IW +: IW], LSB slice first, on in_stream_tdata with in_stream_tvalid=1 while holding.
REQ-017 Slice index SHALL advance on in_stream_tvalid & in_stream_tready; on the last slice the holding register empties.
REQ-018 lii_in_p0_tready SHALL be 1 when holding register empty, or when last slice is handshaking that cycle (back-to-back beats, no bubble).
REQ-019 An accepted beat with lii_in_p0_dst != LOCAL_ID SHALL be discarded (never presented to kernel) and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-020 First slice of an accepted beat SHALL appear on in_stream_tdata the cycle after acceptance (1-cycle latency).
REQ-021 Output packer SHALL accumulate OW words LSB-first into a PW accumulator with count 0..ROUT; out_stream_tready = !(accumulator full).
REQ-022 Accumulator SHALL transfer to output register when full, or when PKT_WORDS != 0 and packet word counter reaches PKT_WORDS; unfilled upper slices SHALL be zero.
REQ-023 Transfer SHALL occur only when output register is empty or draining that cycle; transfer and a new kernel word in the same cycle SHALL start the new accumulator at count 1.
REQ-024 Packet word counter SHALL reset to 0 after each flush; it counts accepted kernel words independently of ROUT boundaries.
REQ-025 lii_out_p0_tvalid SHALL hold with stable tdata until lii_out_p0_tready; lii_out_p0_src = LOCAL_ID, lii_out_p0_dst = DEST_ID.
REQ-026 ce SHALL be 0 only when accumulator full and output register full and lii_out_p0_tready = 0; otherwise 1.
REQ-027 No beat or word SHALL be lost or duplicated under arbitrary tvalid/tready patterns on all four interfaces.

Reset
REQ-028 During arstn=0: lii_in_p0_tready=0, in_stream_tvalid=0, lii_out_p0_tvalid=0, lii_out_p0_tdata=0, out_stream_tready=0, ce=0, drop_cnt=0, all counters and indices 0.
REQ-029 After arstn release, lii_in_p0_tready, out_stream_tready and ce SHALL be 1 from the first clock edge; reset mid-transfer discards all held data.

Verification
REQ-030 PW=64,IW=16: beat 64'h0004_0003_0002_0001, dst=LOCAL_ID, kernel ready=1 -> in_stream_tdata 1,2,3,4 on four consecutive cycles; second beat back-to-back accepted with no idle cycle.
REQ-031 Beat with dst=8'h7F (LOCAL_ID=0) -> no in_stream_tvalid, drop_cnt 0->1; 65536 such beats -> drop_cnt holds 16'hFFFF.
REQ-032 OW=16, PKT_WORDS=0: kernel words 5,6,7,8 -> one output beat 64'h0008_0007_0006_0005, src=LOCAL_ID, dst=DEST_ID.
REQ-033 PKT_WORDS=6: words 1..6 -> beats 64'h0004_0003_0002_0001 then 64'h0000_0000_0006_0005.
REQ-034 lii_out_p0_tready=0 with 8 words offered -> out_stream_tready=0 and ce=0 after 8th word; tready=1 releases both beats in order, tdata stable while stalled.
REQ-035 arstn pulsed low mid-slice and mid-accumulation -> all outputs at REQ-028 values; post-reset stream restarts from fresh beats with no stale data.

Source files
------------

// File: rtl/lii_gearbox_wrapper.sv
// LII phy <-> kernel gearbox: unpacks PW beats into IW words, packs OW words into PW beats.
// Ports: aclk/arstn, lii_in_p0_* (phy in), lii_out_p0_* (phy out), in/out_stream_* (kernel), ce, drop_cnt.
module lii_gearbox_wrapper #(
  parameter int          PW        = 64,
  parameter int          IW        = 16,
  parameter int          OW        = 16,
  parameter logic [7:0]  LOCAL_ID  = 8'h00,
  parameter logic [7:0]  DEST_ID   = 8'h01,
  parameter int          PKT_WORDS = 0
) (
  input  logic          aclk,
  input  logic          arstn,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic          lii_in_p0_tready,
  output logic [PW-1:0] lii_out_p0_tdata,
  output logic          lii_out_p0_tvalid,
  output logic [7:0]    lii_out_p0_src,
  output logic [7:0]    lii_out_p0_dst,
  input  logic          lii_out_p0_tready,
  output logic [IW-1:0] in_stream_tdata,
  output logic          in_stream_tvalid,
  input  logic          in_stream_tready,
  input  logic [OW-1:0] out_stream_tdata,
  input  logic          out_stream_tvalid,
  output logic          out_stream_tready,
  output logic          ce,
  output logic [15:0]   drop_cnt
);

  localparam int RIN = PW / IW;
  localparam int ROUT = PW / OW;
  localparam int IXW = (RIN > 1) ? $clog2(RIN) : 1;
  localparam int CW = $clog2(ROUT + 1);
  localparam int PCW = $clog2(PKT_WORDS + 2);

  logic            r_run;
  logic            r_in_full;
  logic [PW-1:0]   r_in_data;
  logic [IXW-1:0]  r_in_idx;
  logic [15:0]     r_drop;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PCW-1:0]  r_pkt;
  logic            r_out_full;
  logic [PW-1:0]   r_out_data;

  logic            w_in_hs;
  logic            w_in_last;
  logic            w_in_rdy;
  logic            w_in_acc;
  logic            w_in_keep;
  logic [IW-1:0]   w_slice;
  logic            w_pkt_done;
  logic            w_acc_full;
  logic            w_xfer;
  logic            w_k_rdy;
  logic            w_k_hs;
  logic [CW-1:0]   w_wr_idx;
  logic [PW-1:0]   w_acc_nxt;
  logic            w_unused;

  assign w_unused = ^lii_in_p0_src;

  // r_run holds the handshakes low while reset is asserted
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign w_in_hs   = r_in_full & in_stream_tready;
  assign w_in_last = (r_in_idx == IXW'(RIN - 1));
  assign w_in_rdy  = r_run & (!r_in_full | (w_in_hs & w_in_last));
  assign w_in_acc  = lii_in_p0_tvalid & w_in_rdy;
  assign w_in_keep = (lii_in_p0_dst == LOCAL_ID);

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_in_full <= 1'b0;
      r_in_data <= '0;
      r_in_idx  <= '0;
      r_drop    <= '0;
    end else if (w_in_acc) begin
      r_in_full <= w_in_keep;
      r_in_idx  <= '0;
      if (w_in_keep)
        r_in_data <= lii_in_p0_tdata;
      else if (r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
    end else if (w_in_hs) begin
      if (w_in_last) begin
        r_in_full <= 1'b0;
        r_in_idx  <= '0;
      end else begin
        r_in_idx <= r_in_idx + IXW'(1);
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < RIN; i++)
      if (r_in_idx == IXW'(i)) w_slice = r_in_data[i*IW +: IW];
  end

  // a reached packet boundary blocks the accumulator like a full one
  assign w_pkt_done = (PKT_WORDS != 0) && (r_pkt == PCW'(PKT_WORDS));
  assign w_acc_full = (r_cnt == CW'(ROUT)) | w_pkt_done;
  assign w_xfer     = w_acc_full & (!r_out_full | lii_out_p0_tready);
  assign w_k_rdy    = r_run & (!w_acc_full | w_xfer);
  assign w_k_hs     = out_stream_tvalid & w_k_rdy;
  assign w_wr_idx   = w_xfer ? '0 : r_cnt;

  // a transfer restarts the accumulator zeroed, so short packets pad with 0
  always_comb begin
    w_acc_nxt = w_xfer ? '0 : r_acc;
    for (int i = 0; i < ROUT; i++)
      if (w_k_hs && (w_wr_idx == CW'(i)))
        w_acc_nxt[i*OW +: OW] = out_stream_tdata;
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_pkt      <= '0;
      r_out_full <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      if (w_xfer)
        r_cnt <= CW'(w_k_hs);
      else if (w_k_hs)
        r_cnt <= r_cnt + CW'(1);
      if (w_pkt_done && w_xfer)
        r_pkt <= PCW'(w_k_hs);
      else if (w_k_hs && (PKT_WORDS != 0))
        r_pkt <= r_pkt + PCW'(1);
      if (w_xfer) begin
        r_out_full <= 1'b1;
        r_out_data <= r_acc;
      end else if (r_out_full && lii_out_p0_tready) begin
        r_out_full <= 1'b0;
      end
    end
  end

  assign lii_in_p0_tready  = w_in_rdy;
  assign in_stream_tvalid  = r_in_full;
  assign in_stream_tdata   = w_slice;
  assign drop_cnt          = r_drop;
  assign out_stream_tready = w_k_rdy;
  assign ce                = w_k_rdy;
  assign lii_out_p0_tvalid = r_out_full;
  assign lii_out_p0_tdata  = r_out_data;
  assign lii_out_p0_src    = LOCAL_ID;
  assign lii_out_p0_dst    = DEST_ID;

endmodule

// File: tb/tb_lii_gearbox_wrapper.sv
// Bench for lii_gearbox_wrapper: two instances (PKT_WORDS 0 and 6)
// against a queue-based reference model.
module tb_lii_gearbox_wrapper;
  typedef logic [63:0] q64_t[$];

  logic aclk = 1'b0;
  logic arstn = 1'b0;
  always #5 aclk = ~aclk;

  logic [63:0] li_data = '0;
  logic        li_valid = 1'b0;
  logic [7:0]  li_dst = 8'h00;
  logic [7:0]  li_src = 8'h55;
  logic        ki_ready = 1'b0;
  logic [15:0] ko_data = '0;
  logic        ko_v0 = 1'b0;
  logic        ko_v6 = 1'b0;
  logic        lo_ready = 1'b0;

  logic        li_rdy0, li_rdy6, ks_v0, ks_v6, ko_rdy0, ko_rdy6;
  logic        lo_v0, lo_v6, ce0, ce6;
  logic [15:0] ks_d0, ks_d6, drop0, drop6;
  logic [63:0] lo_d0, lo_d6;
  logic [7:0]  lo_s0, lo_s6, lo_t0, lo_t6;

  lii_gearbox_wrapper #(.PKT_WORDS(0)) u0 (
    .aclk(aclk), .arstn(arstn),
    .lii_in_p0_tdata(li_data), .lii_in_p0_tvalid(li_valid),
    .lii_in_p0_src(li_src), .lii_in_p0_dst(li_dst),
    .lii_in_p0_tready(li_rdy0),
    .lii_out_p0_tdata(lo_d0), .lii_out_p0_tvalid(lo_v0),
    .lii_out_p0_src(lo_s0), .lii_out_p0_dst(lo_t0),
    .lii_out_p0_tready(lo_ready),
    .in_stream_tdata(ks_d0), .in_stream_tvalid(ks_v0),
    .in_stream_tready(ki_ready),
    .out_stream_tdata(ko_data), .out_stream_tvalid(ko_v0),
    .out_stream_tready(ko_rdy0),
    .ce(ce0), .drop_cnt(drop0));

  lii_gearbox_wrapper #(.PKT_WORDS(6)) u6 (
    .aclk(aclk), .arstn(arstn),
    .lii_in_p0_tdata(li_data), .lii_in_p0_tvalid(li_valid),
    .lii_in_p0_src(li_src), .lii_in_p0_dst(li_dst),
    .lii_in_p0_tready(li_rdy6),
    .lii_out_p0_tdata(lo_d6), .lii_out_p0_tvalid(lo_v6),
    .lii_out_p0_src(lo_s6), .lii_out_p0_dst(lo_t6),
    .lii_out_p0_tready(lo_ready),
    .in_stream_tdata(ks_d6), .in_stream_tvalid(ks_v6),
    .in_stream_tready(ki_ready),
    .out_stream_tdata(ko_data), .out_stream_tvalid(ko_v6),
    .out_stream_tready(ko_rdy6),
    .ce(ce6), .drop_cnt(drop6));

  int n_cmp = 0;
  int n_err = 0;

  q64_t got_k, exp_k, w0, w6, g0, g6;
  logic [15:0] exp_drop = '0;
  int sv0 = 0, sv6 = 0, kdiff = 0;
  logic st0 = 1'b0, st6 = 1'b0;
  logic [63:0] pd0 = '0, pd6 = '0;

  // observer: handshakes sampled mid-cycle, model queues cleared by reset
  always @(negedge aclk) begin
    if (!arstn) begin
      got_k.delete(); exp_k.delete();
      w0.delete(); w6.delete(); g0.delete(); g6.delete();
      exp_drop <= '0;
      st0 <= 1'b0;
      st6 <= 1'b0;
    end else begin
      if (li_valid && li_rdy0) begin
        if (li_dst == 8'h00)
          for (int s = 0; s < 4; s++)
            exp_k.push_back(64'(li_data[s*16 +: 16]));
        else if (exp_drop != 16'hFFFF)
          exp_drop <= exp_drop + 16'd1;
      end
      if (ks_v0 && ki_ready) got_k.push_back(64'(ks_d0));
      if ((ks_v6 !== ks_v0) || (ks_v0 && (ks_d6 !== ks_d0)) ||
          (li_rdy6 !== li_rdy0) || (drop6 !== drop0))
        kdiff <= kdiff + 1;
      if (ko_v0 && ko_rdy0) w0.push_back(64'(ko_data));
      if (ko_v6 && ko_rdy6) w6.push_back(64'(ko_data));
      if (lo_v0 && lo_ready) g0.push_back(lo_d0);
      if (lo_v6 && lo_ready) g6.push_back(lo_d6);
      if (st0 && (!lo_v0 || (lo_d0 !== pd0))) sv0 <= sv0 + 1;
      if (st6 && (!lo_v6 || (lo_d6 !== pd6))) sv6 <= sv6 + 1;
      st0 <= lo_v0 && !lo_ready;
      st6 <= lo_v6 && !lo_ready;
      pd0 <= lo_d0;
      pd6 <= lo_d6;
    end
  end

  // words packed LSB-first, 4 per beat, cut early at packet end
  function automatic q64_t pack(input q64_t w, input int pkt);
    q64_t b;
    logic [63:0] cur;
    int k, p;
    cur = '0; k = 0; p = 0;
    foreach (w[i]) begin
      cur = cur | (w[i] << (16 * k));
      k++; p++;
      if (k == 4 || (pkt != 0 && p == pkt)) begin
        b.push_back(cur);
        cur = '0; k = 0;
        if (pkt != 0 && p == pkt) p = 0;
      end
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input q64_t g, input q64_t e);
    chk({tag, "_len"}, 64'(g.size()), 64'(e.size()));
    for (int i = 0; i < g.size() && i < e.size(); i++)
      chk(tag, g[i], e[i]);
  endtask

  task automatic tmo(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: handshake observed 0 expected 1 within budget", tag);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] dst);
    int n;
    logic a;
    li_data = d; li_dst = dst; li_valid = 1'b1;
    n = 0; a = 1'b0;
    while (!a && n < 200) begin
      @(negedge aclk); a = li_rdy0;
      @(posedge aclk); #1; n++;
    end
    li_valid = 1'b0;
    if (!a) tmo("beat_timeout");
  endtask

  task automatic send_word(input logic [15:0] d, input logic m0,
                           input logic m6);
    int n;
    logic a0, a6;
    ko_data = d; ko_v0 = m0; ko_v6 = m6; n = 0;
    while ((ko_v0 || ko_v6) && n < 200) begin
      @(negedge aclk);
      a0 = ko_v0 && ko_rdy0;
      a6 = ko_v6 && ko_rdy6;
      @(posedge aclk); #1;
      if (a0) ko_v0 = 1'b0;
      if (a6) ko_v6 = 1'b0;
      n++;
    end
    if (ko_v0 || ko_v6) begin
      tmo("word_timeout");
      ko_v0 = 1'b0; ko_v6 = 1'b0;
    end
  endtask

  task automatic post_rst_chk(input string tag);
    chk({tag, "_in_rdy"}, 64'(li_rdy0), 64'd1);
    chk({tag, "_k_rdy"}, 64'(ko_rdy0), 64'd1);
    chk({tag, "_ce"}, 64'(ce0), 64'd1);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_in_rdy"}, 64'(li_rdy0), 64'd0);
    chk({tag, "_ks_v"}, 64'(ks_v0), 64'd0);
    chk({tag, "_lo_v"}, 64'(lo_v0), 64'd0);
    chk({tag, "_lo_d"}, lo_d0, 64'd0);
    chk({tag, "_k_rdy"}, 64'(ko_rdy0), 64'd0);
    chk({tag, "_ce"}, 64'(ce0), 64'd0);
    chk({tag, "_drop"}, 64'(drop0), 64'd0);
    chk({tag, "_lo_v6"}, 64'(lo_v6), 64'd0);
    chk({tag, "_lo_d6"}, lo_d6, 64'd0);
  endtask

  task automatic do_reset();
    li_valid = 1'b0; ko_v0 = 1'b0; ko_v6 = 1'b0;
    @(negedge aclk); #1 arstn = 1'b0;
    repeat (2) @(negedge aclk);
    #2 arstn = 1'b1;
    @(posedge aclk); #1;
    post_rst_chk("rst");
  endtask

  logic in_done, k_done;
  q64_t e0, e6;

  initial begin
    // reset state
    ki_ready = 1'b1;
    lo_ready = 1'b1;
    repeat (3) @(negedge aclk);
    rst_vals("reset");
    #2 arstn = 1'b1;
    @(posedge aclk); #1;
    post_rst_chk("release");

    // unpack two back-to-back beats
    li_valid = 1'b1; li_dst = 8'h00;
    li_data = 64'h0004_0003_0002_0001;
    cyc(1);
    li_data = 64'h0008_0007_0006_0005;
    for (int i = 0; i < 8; i++) begin
      chk("unpack_v", 64'(ks_v0), 64'd1);
      chk("unpack_d", 64'(ks_d0), 64'(i + 1));
      if (i == 1) chk("in_rdy_busy", 64'(li_rdy0), 64'd0);
      if (i == 3) chk("in_rdy_b2b", 64'(li_rdy0), 64'd1);
      if (i == 4) li_valid = 1'b0;
      cyc(1);
    end
    chk("unpack_idle", 64'(ks_v0), 64'd0);

    // address filter and saturation
    li_dst = 8'h7F; li_data = 64'hDEAD_BEEF_0BAD_F00D; li_valid = 1'b1;
    cyc(1);
    chk("drop_nov", 64'(ks_v0), 64'd0);
    chk("drop_one", 64'(drop0), 64'd1);
    cyc(65535);
    chk("drop_sat", 64'(drop0), 64'hFFFF);
    cyc(3);
    li_valid = 1'b0;
    chk("drop_hold", 64'(drop0), 64'hFFFF);
    chk("drop_model", 64'(drop0), 64'(exp_drop));
    chk("drop_nov2", 64'(ks_v0), 64'd0);
    cmp_q("kslice_dir", got_k, exp_k);

    // pack four words
    do_reset();
    lo_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send_word(16'(i), 1'b1, 1'b1);
    cyc(4);
    chk("pack0_n", 64'(g0.size()), 64'd1);
    chk("pack0_d", g0[0], 64'h0008_0007_0006_0005);
    chk("pack6_d", g6[0], 64'h0008_0007_0006_0005);

    // packet flush at 6 words
    do_reset();
    for (int i = 1; i <= 6; i++) send_word(16'(i), 1'b1, 1'b1);
    cyc(5);
    chk("pkt_n", 64'(g6.size()), 64'd2);
    chk("pkt_b0", g6[0], 64'h0004_0003_0002_0001);
    chk("pkt_b1", g6[1], 64'h0000_0000_0006_0005);
    chk("nopkt_n", 64'(g0.size()), 64'd1);
    e6 = pack(w6, 6);
    cmp_q("pkt_model", g6, e6);

    // output stall backpressure
    do_reset();
    lo_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_word(16'(16 + i), 1'b1, 1'b0);
    chk("stall_krdy", 64'(ko_rdy0), 64'd0);
    chk("stall_ce", 64'(ce0), 64'd0);
    chk("stall_v", 64'(lo_v0), 64'd1);
    chk("stall_d", lo_d0, 64'h0014_0013_0012_0011);
    chk("src", 64'(lo_s0), 64'h00);
    chk("dst", 64'(lo_t0), 64'h01);
    cyc(5);
    chk("stall_hold", lo_d0, 64'h0014_0013_0012_0011);
    chk("stall_ce2", 64'(ce0), 64'd0);
    lo_ready = 1'b1;
    cyc(4);
    e0 = pack(w0, 0);
    cmp_q("stall_model", g0, e0);
    chk("stall_b1", g0[1], 64'h0018_0017_0016_0015);
    chk("stall_ce_rel", 64'(ce0), 64'd1);

    // reset mid-slice and mid-accumulation
    do_reset();
    ki_ready = 1'b0;
    send_beat(64'h1111_2222_3333_4444, 8'h7F);
    send_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'h00);
    ki_ready = 1'b1;
    cyc(1);
    ki_ready = 1'b0;
    lo_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_word(16'hE0 + 16'(i), 1'b1, 1'b0);
    chk("mid_drop", 64'(drop0), 64'd1);
    #2 arstn = 1'b0;
    #1;
    rst_vals("midrst");
    repeat (2) @(negedge aclk);
    #2 arstn = 1'b1;
    @(posedge aclk); #1;
    post_rst_chk("midrel");
    ki_ready = 1'b1;
    lo_ready = 1'b1;
    send_beat(64'h0040_0030_0020_0010, 8'h00);
    chk("fresh_d", 64'(ks_d0), 64'h0010);
    for (int i = 0; i < 4; i++) send_word(16'h70 + 16'(i), 1'b1, 1'b1);
    cyc(8);
    cmp_q("fresh_k", got_k, exp_k);
    chk("fresh_n", 64'(g0.size()), 64'd1);
    chk("fresh_b", g0[0], 64'h0073_0072_0071_0070);

    // random traffic on all four interfaces
    do_reset();
    in_done = 1'b0;
    k_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 30; b++) begin
          cyc($urandom_range(0, 2));
          send_beat({$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 8'h7F : 8'h00);
        end
        in_done = 1'b1;
      end
      begin
        for (int w = 0; w < 48; w++) begin
          cyc($urandom_range(0, 2));
          send_word(16'($urandom), 1'b1, 1'b1);
        end
        k_done = 1'b1;
      end
      begin
        while (!(in_done && k_done)) begin
          ki_ready = 1'($urandom);
          lo_ready = 1'($urandom);
          cyc(1);
        end
        ki_ready = 1'b1;
        lo_ready = 1'b1;
      end
    join
    cyc(20);
    cmp_q("rnd_k", got_k, exp_k);
    e0 = pack(w0, 0);
    e6 = pack(w6, 6);
    cmp_q("rnd_out0", g0, e0);
    cmp_q("rnd_out6", g6, e6);
    chk("rnd_out6_n", 64'(g6.size()), 64'd16);
    chk("rnd_drop", 64'(drop0), 64'(exp_drop));
    chk("stable0", 64'(sv0), 64'd0);
    chk("stable6", 64'(sv6), 64'd0);
    chk("inst_match", 64'(kdiff), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
